seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Display-side counterpart of the digit collapse logic: takes four 4-bit digit values and time-multiplexes them onto one shared 7-segment bus.
- Provides per-digit anode select, hex-to-segment decode and inter-digit blanking to suppress ghosting.
- Frame-synchronous load: a new 4-digit value is committed only at a frame boundary, so the display never tears.
- Sits between the numeric datapath and the board's 4-digit common-anode display pins.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot; legal range > BLANK_CYC, >= 2.
BLANK_CYC, 16, cycles at the start of each slot with all anodes off; 0 disables blanking.
SEG_ACTIVE_LOW, 1, 1 = seg output inverted (segment on = 0); 0 = segment on = 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
load  input  1  one-cycle request to capture w3..w0 into the shadow register.
w3  input  4  digit 3 value (leftmost).
w2  input  4  digit 2 value.
w1  input  4  digit 1 value.
w0  input  4  digit 0 value (rightmost).
an  output  4  anode enables, active-low; an[i] = 0 lights digit i.
seg  output  7  segments {g,f,e,d,c,b,a}; seg[0] = a; polarity per SEG_ACTIVE_LOW.
ack  output  1  one-cycle pulse: shadow value committed to the display.
frame_tick  output  1  one-cycle pulse at the end of each 4-digit frame.

Behaviour:
- Interface (fixed): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset state (asserted immediately, no clock needed):
  - cnt = 0, idx = 0.
  - Display regs and shadow regs = 0; pending = 0.
  - an = 4'b1111.
  - seg = all segments off: 7'h7F if SEG_ACTIVE_LOW, else 7'h00.
  - ack = 0, frame_tick = 0.
- Prescaler `cnt` counts 0..CLK_DIV-1 and then wraps to 0.
  - On wrap, `idx` advances 0→1→2→3→0.
  - end_slot = (cnt == CLK_DIV-1); end_frame = end_slot && idx == 3.
- Outputs an and seg are registered, one cycle after the (cnt, idx) state that produces them:
  - If cnt < BLANK_CYC: an = 1111 and seg = off.
  - Otherwise: an = ~(4'b0001 << idx) and seg = decode(display[idx]).
- Decode table (active-high form; inverted when SEG_ACTIVE_LOW):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Load handshake:
  - load = 1 captures w3..w0 into the shadow register and sets pending.
  - A later load before commit overwrites the shadow (last-writer wins). No data is ever refused.
- Commit, on end_frame with pending = 1:
  - display <= shadow, pending <= 0.
  - ack = 1 on the next cycle, for exactly one cycle.
- load coincident with end_frame: w3..w0 go straight into display (bypass), pending <= 0, ack pulses. The fresh value is never delayed a full frame.
- frame_tick = 1 on the cycle after every end_frame, whether or not a commit occurred.
- No pending at end_frame: display unchanged, ack stays 0.
- Reset asserted mid-frame or mid-commit: all state returns to the reset values; any pending load is discarded.
- Width rules:
  - cnt is $clog2(CLK_DIV) bits and wraps without overflow.
  - idx is 2 bits and wraps naturally from 3 to 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: for each digit i in 3..1, if display[i] == 0 and every digit above i is 0, digit i shows segments off, but its anode slot still runs so timing is unchanged. Digit 0 always displays.
- Undefined: all four digits always show their decoded value, including leading zeros.

Test Plan:
1. Reset, with CLK_DIV=8, BLANK_CYC=2 → an = 1111, seg = 7F, ack = 0. Hold rst_n low for 20 cycles → outputs stay at reset values.
2. Load w3..w0 = 1,2,3,4 mid-frame → ack pulses once, cycle after end_frame. Following frame:
   - digit 0: an = 1110, seg = ~66.
   - digit 1: an = 1101, seg = ~4F.
   - digit 2: an = 1011, seg = ~5B.
   - digit 3: an = 0111, seg = ~06.
   - Each slot shows an = 1111 for its first 2 cycles.
3. Two loads in one frame (values A,B,C,D then 5,6,7,8) → a single ack. Next frame displays 5,6,7,8 (digit 0 = ~79 first is wrong; digit 0 shows ~7F for 8).
4. load asserted exactly on the end_frame cycle with F,E,d,0 → ack on the next cycle. The next frame starts with digit 0 = ~3F, with no one-frame lag.
5. rst_n pulsed low at cnt = 5, idx = 2, with pending = 1 → an = 1111 immediately. After release: no ack, display = 0000.
6. With LEADING_ZERO_BLANK_EN and value 0,0,4,0 → digits 3 and 2 show 7F, digit 1 shows ~66, digit 0 shows ~3F. Without the macro → digits 3 and 2 show ~3F.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans four 4-bit digits onto a shared 7-segment bus of a
// 4-digit common-anode display. A new digit set is committed only at a frame
// boundary so a frame never mixes old and new digits. Each digit slot begins
// with BLANK_CYC cycles of all-anodes-off to suppress ghosting.
// Optional build macro: LEADING_ZERO_BLANK_EN. When it is defined, leading
// zero digits 3..1 are shown blank. Their anode slots still run.
module seg_scan_driver #(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYC      = 16,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] w3,
  input  logic [3:0] w2,
  input  logic [3:0] w1,
  input  logic [3:0] w0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       ack,
  output logic       frame_tick
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [6:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0][3:0]  r_disp;
  logic [3:0][3:0]  r_shadow;
  logic             r_pending;
  logic             r_ack;
  logic             r_frame_tick;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic [3:0][3:0]  w_in;
  logic             w_end_slot;
  logic             w_end_frame;
  logic             w_blank;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg_on;
  logic [3:0]       w_an_next;
  logic [6:0]       w_seg_next;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign w_in        = {w3, w2, w1, w0};
  assign w_end_slot  = (r_cnt == CNT_LAST);
  assign w_end_frame = w_end_slot && (r_idx == 2'd3);
  assign w_blank     = (32'(r_cnt) < 32'(BLANK_CYC));

`ifdef LEADING_ZERO_BLANK_EN
  // w_lz[i] is set when digit i and every digit above it are zero.
  // Digit 0 is never suppressed.
  logic [3:0] w_lz;
  assign w_lz[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lz
    assign w_lz[gi] = (r_disp[3:gi] == '0);
  end
`endif

  // Next an/seg values for the current slot position.
  always_comb begin
    w_digit  = r_disp[r_idx];
    w_seg_on = hex_to_seg(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (w_lz[r_idx]) w_seg_on = 7'h00;
`endif
    w_an_next  = 4'hF;
    w_seg_next = SEG_OFF;
    if (!w_blank) begin
      w_an_next  = ~(4'b0001 << r_idx);
      w_seg_next = (SEG_ACTIVE_LOW != 0) ? ~w_seg_on : w_seg_on;
    end
  end

  // Slot prescaler. The digit index advances when the prescaler wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_end_slot) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shadow capture and frame-boundary commit.
  // A load on the frame boundary bypasses the shadow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp       <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_ack        <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_end_frame;
      if (w_end_frame && load) begin
        r_disp    <= w_in;
        r_pending <= 1'b0;
        r_ack     <= 1'b1;
      end else if (w_end_frame && r_pending) begin
        r_disp    <= r_shadow;
        r_pending <= 1'b0;
        r_ack     <= 1'b1;
      end else begin
        r_ack <= 1'b0;
        if (load) begin
          r_shadow  <= w_in;
          r_pending <= 1'b1;
        end
      end
    end
  end

  // Registered display pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'hF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign ack        = r_ack;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver. A cycle-position reference model pushes the
// expected pin values for every clock into a queue. A monitor pops one entry
// on each falling edge and compares it with the DUT outputs.
module tb_seg_scan_driver;

  localparam int CD    = 8;
  localparam int BL    = 2;
  localparam int SAL   = 1;
  localparam int FRAME = 4 * CD;
  localparam logic [6:0] OFF = (SAL != 0) ? 7'h7F : 7'h00;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       ack;
    logic       ft;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] w3 = 4'h0, w2 = 4'h0, w1 = 4'h0, w0 = 4'h0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       ack;
  logic       frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_seen = 0;
  int ack_exp  = 0;

  exp_t exp_q[$];

  // Reference-model state: a count of clock edges since reset, plus digit
  // values held as plain arrays.
  int         m_p = 0;
  logic [3:0] m_disp   [4];
  logic [3:0] m_shadow [4];
  logic       m_pending = 1'b0;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_driver #(
    .CLK_DIV       (CD),
    .BLANK_CYC     (BL),
    .SEG_ACTIVE_LOW(SAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .w3        (w3),
    .w2        (w2),
    .w1        (w1),
    .w0        (w0),
    .an        (an),
    .seg       (seg),
    .ack       (ack),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  // Expected segment pins for one digit slot, computed from the current model digits.
  function automatic logic [6:0] exp_seg(input int slot);
    logic [6:0] v;
    v = seg_tbl[m_disp[slot]];
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0) begin
      bit all_zero;
      all_zero = 1'b1;
      for (int j = slot; j < 4; j++) if (m_disp[j] != 4'h0) all_zero = 1'b0;
      if (all_zero) v = 7'h00;
    end
`endif
    return (SAL != 0) ? ~v : v;
  endfunction

  // One model step per rising edge. Each step predicts the pins seen after
  // that edge and then applies any load or commit.
  task automatic model_step();
    exp_t e;
    int   fr, slot, c;
    bit   endf;
    if (!rst_n) begin
      m_p = 0;
      m_pending = 1'b0;
      for (int j = 0; j < 4; j++) begin
        m_disp[j] = 4'h0;
        m_shadow[j] = 4'h0;
      end
      return;
    end
    fr   = m_p % FRAME;
    slot = fr / CD;
    c    = fr % CD;
    endf = (fr == FRAME - 1);
    e.an  = (c < BL) ? 4'hF : ~(4'b0001 << slot);
    e.seg = (c < BL) ? OFF : exp_seg(slot);
    e.ack = endf && (m_pending || load);
    e.ft  = endf;
    exp_q.push_back(e);
    if (endf && load) begin
      m_disp = '{w0, w1, w2, w3};
      m_pending = 1'b0;
    end else begin
      if (endf && m_pending) begin
        m_disp = m_shadow;
        m_pending = 1'b0;
      end
      if (load) begin
        m_shadow = '{w0, w1, w2, w3};
        m_pending = 1'b1;
      end
    end
    m_p++;
  endtask

  initial begin
    for (int j = 0; j < 4; j++) begin
      m_disp[j] = 4'h0;
      m_shadow[j] = 4'h0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares DUT pins with the scoreboard on every falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        check("rst_an", 32'(an), 32'h0000000F);
        check("rst_seg", 32'(seg), 32'(OFF));
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_ftick", 32'(frame_tick), 32'd0);
      end else if (exp_q.size() == 0) begin
        check("sb_underrun", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        if (ack) ack_seen++;
        if (e.ack) ack_exp++;
        check("an", 32'(an), 32'(e.an));
        check("seg", 32'(seg), 32'(e.seg));
        check("ack", 32'(ack), 32'(e.ack));
        check("frame_tick", 32'(frame_tick), 32'(e.ft));
      end
    end
  end

  task automatic wait_pos(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_p % FRAME) != target && n < 2 * FRAME + 4);
    if ((m_p % FRAME) != target) check("wait_pos_timeout", 32'(m_p % FRAME), 32'(target));
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    $display("[TB] load w3..w0=%h%h%h%h at frame pos %0d", a, b, c, d, m_p % FRAME);
    load = 1'b1;
    w3 = a; w2 = b; w1 = c; w0 = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hold reset for 20 cycles. The monitor checks the reset values on every cycle.
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b1;

    // Single load in the middle of a frame.
    wait_pos(10);
    do_load(4'h1, 4'h2, 4'h3, 4'h4);
    run_frames(2);

    // Two loads in one frame: the last one wins and only one ack is issued.
    wait_pos(5);
    do_load(4'hA, 4'hB, 4'hC, 4'hD);
    wait_pos(20);
    do_load(4'h5, 4'h6, 4'h7, 4'h8);
    run_frames(2);

    // Load on the end-of-frame cycle bypasses the shadow register.
    wait_pos(FRAME - 1);
    do_load(4'hF, 4'hE, 4'hD, 4'h0);
    run_frames(2);

    // Leading-zero pattern.
    wait_pos(3);
    do_load(4'h0, 4'h0, 4'h4, 4'h0);
    run_frames(2);

    // Reset pulse at cnt=5, idx=2 while a load is pending.
    wait_pos(10);
    do_load(4'h9, 4'h9, 4'h9, 4'h9);
    wait_pos(2 * CD + 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'h0000000F);
    check("async_rst_seg", 32'(seg), 32'(OFF));
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    run_frames(2);

    // Random loads, some of them on the end-of-frame cycle.
    for (int i = 0; i < 30; i++) begin
      int r;
      logic [3:0] a, b, c, d;
      r = $urandom_range(0, 3);
      a = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      b = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      c = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      if (r == 0) wait_pos(FRAME - 1);
      else repeat ($urandom_range(1, 40)) @(negedge clk);
      do_load(a, b, c, d);
    end
    run_frames(2);

    check("ack_count", 32'(ack_seen), 32'(ack_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
